// File: rtl/alu_result_collector_if.sv
// Bundle between a bit-serial 1-bit ALU slice and its result collector.
//
// Handshake: a slice result beat (Y1/Y0/Zero/Error) is transferred on
// every rising clk edge where bit_valid=1 and busy=1. busy is the ready
// side. There is no backpressure beyond busy, and beats sent while busy=0
// are dropped. start has priority over bit_valid.
//
// Optional build macro: COLLECT_OVERFLOW_EN adds the overflow signal.
interface alu_result_collector_if #(
  parameter int WIDTH = 8
);

  // Slice / controller -> collector
  logic             start;
  logic             bit_valid;
  logic             Y1;
  logic             Y0;
  logic             Zero;
  logic             Error;

  // Collector -> slice / controller
  logic             busy;
  logic             cin_next;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero_flag;
  logic             err;
  logic             done;
`ifdef COLLECT_OVERFLOW_EN
  logic             overflow;
`endif

  // Encoded FSM state, exposed for checkers
  logic [1:0]       dbg_state;

  modport master (
    output start,
    output bit_valid,
    output Y1,
    output Y0,
    output Zero,
    output Error,
    input  busy,
    input  cin_next,
    input  result,
    input  carry_out,
    input  zero_flag,
    input  err,
    input  done,
`ifdef COLLECT_OVERFLOW_EN
    input  overflow,
`endif
    input  dbg_state
  );

  modport slave (
    input  start,
    input  bit_valid,
    input  Y1,
    input  Y0,
    input  Zero,
    input  Error,
    output busy,
    output cin_next,
    output result,
    output carry_out,
    output zero_flag,
    output err,
    output done,
`ifdef COLLECT_OVERFLOW_EN
    output overflow,
`endif
    output dbg_state
  );

endinterface

// File: rtl/alu_result_collector.sv
// Result collector for the bit-serial 1-bit ALU slice.
//
// Takes one slice beat per accepted bit_valid, shifts the sum bits in
// LSB-first to form a WIDTH-bit word, and feeds the latest carry back
// to the slice through cin_next. At the end of a word it pulses done
// for one cycle with the word, final carry, zero and error flags.
// An Error beat or a Zero flag that disagrees with Y1:Y0 ends the word
// early with err=1.
//
// Optional build macro: COLLECT_OVERFLOW_EN adds a signed overflow flag
// (carry into the MSB xor carry out of the MSB).
module alu_result_collector #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_result_collector_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_CIN_CNT = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] result_q;
  logic             cin_q;
  logic             carry_q;
  logic             zero_q;
  logic             err_q;

  // Beat qualification. start wins over a simultaneous beat.
  logic             accept;
  logic             shift_en;
  logic             slice_err;
  logic             incons;
  logic             last_beat;
  logic             finish;
  logic [WIDTH-1:0] result_sh;

  assign accept    = (state == S_COLLECT) && bus.bit_valid && !bus.start;
  // An Error beat is never shifted in; every other accepted beat is.
  assign shift_en  = accept && !bus.Error;
  assign slice_err = accept && bus.Error;
  // Zero must mean Y1:Y0 == 00; a disagreement is an error, but the
  // beat itself is still kept in the partial word.
  assign incons    = shift_en && bus.Zero && (bus.Y1 || bus.Y0);
  assign last_beat = shift_en && (cnt == LAST_CNT);
  assign finish    = slice_err || incons || last_beat;
  assign result_sh = {bus.Y0, result_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nx = S_COLLECT;
      end
      S_COLLECT: begin
        if (bus.start)   state_nx = S_COLLECT;
        else if (finish) state_nx = S_DONE;
      end
      S_DONE: begin
        // DONE is always exactly one cycle; start here skips IDLE.
        if (bus.start) state_nx = S_COLLECT;
        else           state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Word accumulation, carry feedback and completion flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      result_q <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (bus.start) begin
      cnt      <= '0;
      result_q <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (shift_en) begin
      result_q <= result_sh;
      cin_q    <= bus.Y1;
      cnt      <= cnt + CW'(1);
      if (incons) begin
        // Early abort: carry/zero stay at their cleared value of 0.
        err_q <= 1'b1;
      end else if (last_beat) begin
        carry_q <= bus.Y1;
        zero_q  <= (result_sh == '0);
      end
    end else if (slice_err) begin
      err_q <= 1'b1;
    end
  end

`ifdef COLLECT_OVERFLOW_EN
  logic cin_msb_q;
  logic ovf_q;

  // Capture the carry into the MSB and form overflow on a clean finish
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cin_msb_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (bus.start) begin
      cin_msb_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (shift_en && !incons) begin
      // Beat WIDTH-1 produces the carry into bit WIDTH-1.
      if (cnt == MSB_CIN_CNT) cin_msb_q <= bus.Y1;
      if (last_beat)          ovf_q     <= cin_msb_q ^ bus.Y1;
    end
  end

  assign bus.overflow = ovf_q;
`else
  // Keeps the unused constant referenced in builds without overflow.
  logic unused_msb_cnt;
  assign unused_msb_cnt = ^MSB_CIN_CNT;
`endif

  assign bus.busy      = (state == S_COLLECT);
  assign bus.done      = (state == S_DONE);
  assign bus.cin_next  = cin_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.zero_flag = zero_q;
  assign bus.err       = err_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector at WIDTH=4.
// Inputs change on the falling edge; outputs are checked on the falling
// edge after the rising edge that updated them.
module tb_alu_result_collector;

  localparam int W = 4;

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_result_collector_if #(.WIDTH(W)) bus ();

  alu_result_collector #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;
  int done_base   = 0;

  // Expected completed words, pushed before each word is driven
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_word;

  // Count every done pulse seen
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag);
    exp_word = exp_q.pop_front();
    chk(tag, 32'(bus.result), 32'(exp_word));
  endtask

  // Driver tasks
  task automatic drive_idle();
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.Y1        = 1'b0;
    bus.Y0        = 1'b0;
    bus.Zero      = 1'b0;
    bus.Error     = 1'b0;
  endtask

  task automatic idle_cycle();
    drive_idle();
    @(negedge clk);
  endtask

  task automatic do_start();
    drive_idle();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic beat(input logic y1, input logic y0, input logic z, input logic e);
    bus.bit_valid = 1'b1;
    bus.Y1        = y1;
    bus.Y0        = y0;
    bus.Zero      = z;
    bus.Error     = e;
    @(negedge clk);
    bus.bit_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(bus.busy),      32'd0);
    chk({tag, "_done"},   32'(bus.done),      32'd0);
    chk({tag, "_cin"},    32'(bus.cin_next),  32'd0);
    chk({tag, "_result"}, 32'(bus.result),    32'd0);
    chk({tag, "_carry"},  32'(bus.carry_out), 32'd0);
    chk({tag, "_zero"},   32'(bus.zero_flag), 32'd0);
    chk({tag, "_err"},    32'(bus.err),       32'd0);
    chk({tag, "_state"},  32'(bus.dbg_state), 32'd0);
`ifdef COLLECT_OVERFLOW_EN
    chk({tag, "_ovf"},    32'(bus.overflow),  32'd0);
`endif
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b0;
    @(negedge clk);

    // Word 1: bits 1,0,1,1 LSB-first -> 4'hD, carry chain 0,0,0,1
    exp_q.push_back(4'hD);
    do_start();
    chk("w1_busy_rise", 32'(bus.busy), 32'd1);
    chk("w1_cin_start", 32'(bus.cin_next), 32'd0);
    beat(1'b0, 1'b1, 1'b0, 1'b0);
    chk("w1_cin0", 32'(bus.cin_next), 32'd0);
    beat(1'b0, 1'b0, 1'b1, 1'b0);
    chk("w1_cin1", 32'(bus.cin_next), 32'd0);
    beat(1'b0, 1'b1, 1'b0, 1'b0);
    chk("w1_cin2", 32'(bus.cin_next), 32'd0);
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    chk("w1_done",  32'(bus.done),      32'd1);
    chk("w1_busy",  32'(bus.busy),      32'd0);
    chk("w1_cin3",  32'(bus.cin_next),  32'd1);
    chk_word("w1_result");
    chk("w1_carry", 32'(bus.carry_out), 32'd1);
    chk("w1_zero",  32'(bus.zero_flag), 32'd0);
    chk("w1_err",   32'(bus.err),       32'd0);
    idle_cycle();
    chk("w1_done_end", 32'(bus.done),   32'd0);
    chk("w1_hold",     32'(bus.result), 32'hD);
    chk("w1_idle",     32'(bus.dbg_state), 32'd0);

    // Word 2: all-zero beats with consistent Zero flag
    exp_q.push_back(4'h0);
    do_start();
    for (int i = 0; i < W; i++) beat(1'b0, 1'b0, 1'b1, 1'b0);
    chk("w2_done",  32'(bus.done),      32'd1);
    chk_word("w2_result");
    chk("w2_zero",  32'(bus.zero_flag), 32'd1);
    chk("w2_carry", 32'(bus.carry_out), 32'd0);
    chk("w2_err",   32'(bus.err),       32'd0);
    idle_cycle();

    // Word 3: Error on beat 2; only beat 1 (Y0=1) lands, in bit 3
    exp_q.push_back(4'h8);
    do_start();
    beat(1'b0, 1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0, 1'b1);
    chk("w3_done",  32'(bus.done),      32'd1);
    chk("w3_busy",  32'(bus.busy),      32'd0);
    chk("w3_err",   32'(bus.err),       32'd1);
    chk("w3_carry", 32'(bus.carry_out), 32'd0);
    chk("w3_zero",  32'(bus.zero_flag), 32'd0);
    chk_word("w3_result");
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    chk("w3_ign3_done", 32'(bus.done),   32'd0);
    chk("w3_ign3_res",  32'(bus.result), 32'h8);
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    chk("w3_ign4_busy", 32'(bus.busy),   32'd0);
    chk("w3_ign4_res",  32'(bus.result), 32'h8);
    chk("w3_err_hold",  32'(bus.err),    32'd1);
    idle_cycle();

    // Word 4: restart after 2 beats (with a beat on the start cycle)
    done_base = done_seen;
    exp_q.push_back(4'hF);
    do_start();
    beat(1'b0, 1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0, 1'b0);
    bus.start     = 1'b1;
    bus.bit_valid = 1'b1;
    bus.Y1        = 1'b1;
    bus.Y0        = 1'b1;
    @(negedge clk);
    drive_idle();
    chk("w4_restart_busy", 32'(bus.busy),     32'd1);
    chk("w4_restart_res",  32'(bus.result),   32'd0);
    chk("w4_restart_cin",  32'(bus.cin_next), 32'd0);
    for (int i = 0; i < W; i++) beat(1'b0, 1'b1, 1'b0, 1'b0);
    chk("w4_done", 32'(bus.done), 32'd1);
    chk_word("w4_result");
    chk("w4_carry", 32'(bus.carry_out), 32'd0);
    idle_cycle();
    idle_cycle();
    chk("w4_one_done", 32'(done_seen - done_base), 32'd1);

    // Word 5: gapped beats, then asynchronous reset mid-word
    do_start();
    beat(1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycle();
    beat(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    chk("w5_busy_gap", 32'(bus.busy),     32'd1);
    chk("w5_cin_gap",  32'(bus.cin_next), 32'd1);
    done_base = done_seen;
    #2 reset = 1'b1;
    #1 chk_all_zero("w5_async_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) idle_cycle();
    chk("w5_no_done", 32'(done_seen - done_base), 32'd0);
    chk("w5_idle",    32'(bus.dbg_state),         32'd0);

    // Word 6: Zero=1 with Y0=1 is inconsistent; beat kept, immediate done
    exp_q.push_back(4'h8);
    do_start();
    beat(1'b0, 1'b1, 1'b1, 1'b0);
    chk("w6_done",  32'(bus.done),      32'd1);
    chk("w6_err",   32'(bus.err),       32'd1);
    chk_word("w6_result");
    chk("w6_carry", 32'(bus.carry_out), 32'd0);
    chk("w6_zero",  32'(bus.zero_flag), 32'd0);
    idle_cycle();

`ifdef COLLECT_OVERFLOW_EN
    // Carries 0,0,1,0: carry into MSB 1, carry out 0 -> overflow
    exp_q.push_back(4'hF);
    do_start();
    beat(1'b0, 1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovf1_done", 32'(bus.done),     32'd1);
    chk_word("ovf1_result");
    chk("ovf1_ovf",  32'(bus.overflow), 32'd1);
    idle_cycle();
    chk("ovf1_hold", 32'(bus.overflow), 32'd1);

    // Carries 0,0,1,1: carry into MSB 1, carry out 1 -> no overflow
    exp_q.push_back(4'hF);
    do_start();
    chk("ovf2_clear", 32'(bus.overflow), 32'd0);
    beat(1'b0, 1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    chk("ovf2_done",  32'(bus.done),      32'd1);
    chk_word("ovf2_result");
    chk("ovf2_carry", 32'(bus.carry_out), 32'd1);
    chk("ovf2_ovf",   32'(bus.overflow),  32'd0);
    idle_cycle();
`endif

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
